// File: rtl/timekeeper_7seg_if.sv
// Control and display bundle for the 7-segment timekeeper.
// master = panel/controller side, slave = the timekeeper.
interface timekeeper_7seg_if;
  logic       mode_12h;
  logic       show_sec;
  logic       set_en;
  logic       inc_min;
  logic       inc_hr;
  logic [6:0] segments;
  logic [3:0] anodes;
  logic       dp;
  logic       pm;

  modport master (
    output mode_12h, show_sec, set_en,
    output inc_min, inc_hr,
    input  segments, anodes, dp, pm
  );

  modport slave (
    input  mode_12h, show_sec, set_en,
    input  inc_min, inc_hr,
    output segments, anodes, dp, pm
  );
endinterface

// File: rtl/timekeeper_7seg.sv
// hh:mm:ss timekeeper with set mode and a
// 4-digit multiplexed active-low 7-segment display.
module timekeeper_7seg #(
  parameter longint unsigned TICK_DIV  = 100_000_000,
  parameter int              SCAN_BITS = 18
) (
  input  logic             clk,
  input  logic             reset,
  timekeeper_7seg_if.slave tk
);
  localparam int PW =
    (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST =
    PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_HALF =
    PW'(TICK_DIV / 2);
  localparam int SW = SCAN_BITS + 2;

  logic [PW-1:0] presc, presc_d;
  logic [SW-1:0] scan;
  logic [5:0]    secs, secs_d;
  logic [5:0]    mins, mins_d;
  logic [4:0]    hrs, hrs_d;
  logic          tick;

  logic [4:0] hr_disp;
  logic [3:0] h_t, h_u;
  logic [3:0] m_t, m_u;
  logic [3:0] s_t, s_u;
  logic [3:0] nib;
  logic [1:0] idx;
  logic       blank;

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign tick = (presc == P_LAST) && !tk.set_en;

  // Next time state: set-mode edits, or one-second
  // ripple carry sec -> min -> hour in a single edge.
  always_comb begin
    presc_d = presc + PW'(1);
    if (presc == P_LAST) presc_d = '0;
    secs_d = secs;
    mins_d = mins;
    hrs_d  = hrs;
    if (tk.set_en) begin
      presc_d = '0;
      secs_d  = '0;
      if (tk.inc_min)
        mins_d = (mins == 6'd59) ? 6'd0
                                 : mins + 6'd1;
      if (tk.inc_hr)
        hrs_d = (hrs == 5'd23) ? 5'd0
                               : hrs + 5'd1;
    end else if (tick) begin
      if (secs == 6'd59) begin
        secs_d = '0;
        if (mins == 6'd59) begin
          mins_d = '0;
          hrs_d  = (hrs == 5'd23) ? 5'd0
                                  : hrs + 5'd1;
        end else begin
          mins_d = mins + 6'd1;
        end
      end else begin
        secs_d = secs + 6'd1;
      end
    end
  end

  // Time and scan registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      scan  <= '0;
      secs  <= '0;
      mins  <= '0;
      hrs   <= '0;
    end else begin
      presc <= presc_d;
      scan  <= scan + SW'(1);
      secs  <= secs_d;
      mins  <= mins_d;
      hrs   <= hrs_d;
    end
  end

  // Map internal 0..23 hours to the displayed hour.
  always_comb begin
    hr_disp = hrs;
    if (tk.mode_12h) begin
      if (hrs == 5'd0)
        hr_disp = 5'd12;
      else if (hrs > 5'd12)
        hr_disp = hrs - 5'd12;
    end
  end

  assign h_t = 4'(hr_disp / 5'd10);
  assign h_u = 4'(hr_disp % 5'd10);
  assign m_t = 4'(mins / 6'd10);
  assign m_u = 4'(mins % 6'd10);
  assign s_t = 4'(secs / 6'd10);
  assign s_u = 4'(secs % 6'd10);

  assign idx = scan[SW-1:SW-2];

  // Select the BCD nibble for the digit being scanned.
  always_comb begin
    nib   = 4'd0;
    blank = 1'b0;
    unique case (idx)
      2'd3: begin
        if (tk.show_sec) begin
          nib = m_t;
        end else begin
          nib   = h_t;
          blank = tk.mode_12h && (h_t == 4'd0);
        end
      end
      2'd2: nib = tk.show_sec ? m_u : h_u;
      2'd1: nib = tk.show_sec ? s_t : m_t;
      2'd0: nib = tk.show_sec ? s_u : m_u;
    endcase
  end

  assign tk.segments = blank ? 7'b1111111
                             : seg7(nib);
  assign tk.anodes   = ~(4'b0001 << idx);
  assign tk.dp       = !((idx == 2'd2) &&
                         (tk.set_en ||
                          presc < P_HALF));
  assign tk.pm       = tk.mode_12h &&
                       (hrs >= 5'd12);
endmodule

// File: tb/tb_timekeeper_7seg.sv
// Directed bench for timekeeper_7seg
// (TICK_DIV=4, SCAN_BITS=2).
module tb_timekeeper_7seg;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic [6:0] dig [4];
  logic [6:0] e   [4];

  always #5 clk = ~clk;

  timekeeper_7seg_if tk ();

  timekeeper_7seg #(
    .TICK_DIV (4),
    .SCAN_BITS(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tk   (tk)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    tk.mode_12h = 1'b0;
    tk.show_sec = 1'b0;
    tk.set_en   = 1'b0;
    tk.inc_min  = 1'b0;
    tk.inc_hr   = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic pulse_min();
    tk.inc_min = 1'b1;
    cyc(1);
    tk.inc_min = 1'b0;
  endtask

  task automatic pulse_hr();
    tk.inc_hr = 1'b1;
    cyc(1);
    tk.inc_hr = 1'b0;
  endtask

  task automatic set_exp(
    input logic [6:0] d3, input logic [6:0] d2,
    input logic [6:0] d1, input logic [6:0] d0
  );
    e[3] = d3;
    e[2] = d2;
    e[1] = d1;
    e[0] = d0;
  endtask

  // Record what each digit shows over one scan period.
  task automatic capture();
    for (int i = 0; i < 4; i++) dig[i] = 'x;
    for (int c = 0; c < 16; c++) begin
      case (tk.anodes)
        4'b1110: dig[0] = tk.segments;
        4'b1101: dig[1] = tk.segments;
        4'b1011: dig[2] = tk.segments;
        4'b0111: dig[3] = tk.segments;
        default: ;
      endcase
      cyc(1);
    end
  endtask

  task automatic test_reset();
    clr_in();
    tk.set_en  = 1'b1;
    tk.inc_min = 1'b1;
    tk.inc_hr  = 1'b1;
    reset = 1'b1;
    cyc(2);
    vectors++;
    if (tk.anodes !== 4'b1110) begin
      miscompares++;
      $display("FAIL rst_anodes got %b want 1110",
               tk.anodes);
    end
    vectors++;
    if (tk.segments !== S0) begin
      miscompares++;
      $display("FAIL rst_seg got %b want %b",
               tk.segments, S0);
    end
    vectors++;
    if (tk.dp !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_dp got %b want 1", tk.dp);
    end
    vectors++;
    if (tk.pm !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pm got %b want 0", tk.pm);
    end
    clr_in();
    reset = 1'b0;
    capture();
    set_exp(S0, S0, S0, S0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL rst_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
  endtask

  task automatic test_minute();
    do_reset();
    cyc(240);
    vectors++;
    if (tk.anodes !== 4'b1110) begin
      miscompares++;
      $display("FAIL min_anode got %b want 1110",
               tk.anodes);
    end
    vectors++;
    if (tk.segments !== S1) begin
      miscompares++;
      $display("FAIL min_units got %b want %b",
               tk.segments, S1);
    end
    tk.show_sec = 1'b1;
    #1;
    vectors++;
    if (tk.segments !== S0) begin
      miscompares++;
      $display("FAIL sec_units got %b want %b",
               tk.segments, S0);
    end
    capture();
    set_exp(S0, S1, S0, 'x);
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL mmss_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
  endtask

  task automatic test_set_wrap();
    do_reset();
    tk.set_en = 1'b1;
    for (int i = 0; i < 23; i++) pulse_hr();
    for (int i = 0; i < 59; i++) pulse_min();
    capture();
    set_exp(S2, S3, S5, S9);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL set_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
    tk.show_sec = 1'b1;
    capture();
    set_exp(S5, S9, S0, S0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL setsec_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
    tk.show_sec = 1'b0;
    tk.mode_12h = 1'b1;
    tk.set_en   = 1'b0;
    cyc(239);
    vectors++;
    if (tk.pm !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_wrap_pm got %b want 1",
               tk.pm);
    end
    cyc(1);
    vectors++;
    if (tk.pm !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_pm got %b want 0", tk.pm);
    end
    tk.mode_12h = 1'b0;
    capture();
    set_exp(S0, S0, S0, S0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL wrap_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
  endtask

  task automatic test_12h();
    do_reset();
    tk.set_en   = 1'b1;
    tk.mode_12h = 1'b1;
    #1;
    vectors++;
    if (tk.pm !== 1'b0) begin
      miscompares++;
      $display("FAIL h0_pm got %b want 0", tk.pm);
    end
    capture();
    set_exp(S1, S2, S0, S0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL h0_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
    for (int i = 0; i < 13; i++) pulse_hr();
    vectors++;
    if (tk.pm !== 1'b1) begin
      miscompares++;
      $display("FAIL h13_pm got %b want 1", tk.pm);
    end
    capture();
    set_exp(SB, S1, S0, S0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL h13_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
    tk.mode_12h = 1'b0;
    #1;
    vectors++;
    if (tk.pm !== 1'b0) begin
      miscompares++;
      $display("FAIL h13_24_pm got %b want 0",
               tk.pm);
    end
    capture();
    set_exp(S1, S3, S0, S0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL h13_24_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
  endtask

  task automatic test_inc_gate();
    do_reset();
    pulse_min();
    pulse_hr();
    capture();
    set_exp(S0, S0, S0, S0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL gate_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
    tk.set_en  = 1'b1;
    tk.inc_min = 1'b1;
    tk.inc_hr  = 1'b1;
    cyc(1);
    tk.inc_min = 1'b0;
    tk.inc_hr  = 1'b0;
    capture();
    set_exp(S0, S1, S0, S1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL both_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
    tk.show_sec = 1'b1;
    capture();
    set_exp(S0, S1, S0, S0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL bothsec_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] ea;
    logic       ed;
    int         di;
    do_reset();
    for (int k = 0; k < 48; k++) begin
      if (k == 32) begin
        tk.set_en = 1'b1;
        #1;
      end
      di = (k / 4) % 4;
      ea = 4'b1111;
      ea[di] = 1'b0;
      if (k < 32)
        ed = !(di == 2 && (k % 4) < 2);
      else
        ed = !(di == 2);
      vectors++;
      if (tk.anodes !== ea) begin
        miscompares++;
        $display("FAIL scan_an k=%0d got %b want %b",
                 k, tk.anodes, ea);
      end
      vectors++;
      if (tk.dp !== ed) begin
        miscompares++;
        $display("FAIL scan_dp k=%0d got %b want %b",
                 k, tk.dp, ed);
      end
      cyc(1);
    end
  endtask

  task automatic test_reset_in_set();
    do_reset();
    tk.set_en = 1'b1;
    for (int i = 0; i < 12; i++) pulse_hr();
    for (int i = 0; i < 34; i++) pulse_min();
    capture();
    set_exp(S1, S2, S3, S4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL t1234_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
    tk.mode_12h = 1'b1;
    #1;
    vectors++;
    if (tk.pm !== 1'b1) begin
      miscompares++;
      $display("FAIL t1234_pm got %b want 1", tk.pm);
    end
    reset      = 1'b1;
    tk.inc_min = 1'b1;
    tk.inc_hr  = 1'b1;
    cyc(1);
    vectors++;
    if (tk.anodes !== 4'b1110) begin
      miscompares++;
      $display("FAIL rset_anodes got %b want 1110",
               tk.anodes);
    end
    vectors++;
    if (tk.segments !== S0) begin
      miscompares++;
      $display("FAIL rset_seg got %b want %b",
               tk.segments, S0);
    end
    vectors++;
    if (tk.dp !== 1'b1) begin
      miscompares++;
      $display("FAIL rset_dp got %b want 1", tk.dp);
    end
    vectors++;
    if (tk.pm !== 1'b0) begin
      miscompares++;
      $display("FAIL rset_pm got %b want 0", tk.pm);
    end
    reset = 1'b0;
    tk.inc_min  = 1'b0;
    tk.inc_hr   = 1'b0;
    tk.mode_12h = 1'b0;
    capture();
    set_exp(S0, S0, S0, S0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dig[i] !== e[i]) begin
        miscompares++;
        $display("FAIL rset_digit%0d got %b want %b",
                 i, dig[i], e[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    test_reset();
    test_minute();
    test_set_wrap();
    test_12h();
    test_inc_gate();
    test_scan();
    test_reset_in_set();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/timekeeper_7seg.md
TIMEKEEPER_7SEG -- requirements
Module: timekeeper_7seg

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000_000, meaning clk cycles per second (legal range 2 to 2^32).
REQ-002 SHALL have parameter SCAN_BITS, default 18, meaning log2 of clk cycles per displayed digit.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 mode_12h  input  1  1 = 12-hour display, 0 = 24-hour display; level, may change any cycle.
REQ-006 show_sec  input  1  1 = display mm:ss, 0 = display hh:mm; level.
REQ-007 set_en  input  1  1 = time-set mode (timekeeping frozen).
REQ-008 inc_min  input  1  single-cycle pulse, pre-synchronised, advances minutes in set mode.
REQ-009 inc_hr  input  1  single-cycle pulse, pre-synchronised, advances hours in set mode.
REQ-010 segments  output  7  active-low segment drive, bit0=a ... bit6=g.
REQ-011 anodes  output  4  active-low digit enable, bit0 = rightmost digit.
REQ-012 dp  output  1  active-low colon/decimal point.
REQ-013 pm  output  1  active-high PM indicator.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 and wrap; one-cycle tick SHALL assert when prescaler = TICK_DIV-1 and set_en = 0.
REQ-015 On tick, seconds SHALL increment 0..59; at 59 they SHALL wrap to 0 and carry to minutes in the same clock edge.
REQ-016 Minutes SHALL wrap 59->0 with carry to hours; hours SHALL be held internally 0..23 and wrap 23->0; carries ripple combinationally so 23:59:59 -> 00:00:00 in one edge.
REQ-017 While set_en = 1: prescaler and seconds SHALL be held at 0; no tick occurs.
REQ-018 While set_en = 1: inc_min SHALL advance minutes by 1 (59->0, no carry to hours); inc_hr SHALL advance hours by 1 (23->0); both pulses in the same cycle SHALL apply both.
REQ-019 While set_en = 0: inc_min and inc_hr SHALL be ignored.
REQ-020 On set_en falling edge, counting SHALL resume from prescaler 0; first tick occurs TICK_DIV cycles later.
REQ-021 Display hour value: mode_12h = 0 -> internal hours; mode_12h = 1 -> 0 maps to 12, 13..23 map to 1..11, 1..12 unchanged.
REQ-022 pm SHALL equal (internal hours >= 12) when mode_12h = 1, else 0.
REQ-023 In mode_12h = 1 a zero hours-tens digit SHALL be blanked (segments all 1); no other blanking.
REQ-024 show_sec = 0: digits 3..0 = hour tens, hour units, minute tens, minute units; show_sec = 1: minute tens, minute units, second tens, second units (no hour blanking).
REQ-025 Scan counter SHALL be SCAN_BITS+2 bits, free-running, wrapping; digit index = its top two bits.
REQ-026 anodes SHALL be 1110, 1101, 1011, 0111 for digit index 0, 1, 2, 3; exactly one anode low at all times.
REQ-027 segments SHALL be combinational from digit index and current counters; digit codes active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-028 dp SHALL be 0 only when digit index = 2 and (set_en = 1 or prescaler < TICK_DIV/2); otherwise 1.
REQ-029 Display changes SHALL be visible on the cycle after the counter update (no extra pipelining).

Reset
REQ-030 reset SHALL dominate all other inputs, including mid-set and mid-carry.
REQ-031 After reset: prescaler, scan counter, seconds, minutes, hours = 0; anodes = 1110; segments = 1000000; dp = 1; pm = 0.

Verification (TICK_DIV=4, SCAN_BITS=2)
REQ-032 Reset, run 4*60 cycles -> minutes = 1, seconds = 0; digit 0 shows 1111001.
REQ-033 Set mode: 23 inc_hr, 59 inc_min pulses, release, run 4*60 cycles -> 00:00:00, no ripple into day.
REQ-034 hours = 0, mode_12h = 1 -> digits 3,2 show 1111001, 0100100, pm = 0; hours = 13 -> digit 3 blank, digit 2 = 1111001, pm = 1.
REQ-035 inc_min pulse with set_en = 0 -> minutes unchanged; inc_min and inc_hr same cycle with set_en = 1 -> both +1.
REQ-036 Scan check: anodes sequence 1110,1101,1011,0111 each held 4 cycles, repeats every 16 cycles; dp low only on 1011 during prescaler 0..1.
REQ-037 reset asserted during set mode at 12:34 -> all counters 0 next edge, outputs per REQ-031.
